// File: rtl/drac_pkg.sv
// drac_pkg: shared types and sizes for the fetch-stage icache responder.
//   FETCH_ADDR_W   virtual fetch address width
//   ICACHE_LINE_W  icache line width in bits
//   ICACHE_OFF_W   byte-offset bits inside one line
//   icache_line_t  one icache line
//   fetch_resp_state_t  responder FSM states
//   fetch_resp_t   registered response to fetch stage 2
package drac_pkg;

  localparam int FETCH_ADDR_W  = 40;
  localparam int ICACHE_LINE_W = 128;
  localparam int ICACHE_OFF_W  = $clog2(ICACHE_LINE_W / 8);

  typedef logic [ICACHE_LINE_W-1:0] icache_line_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_resp_state_t;

  typedef struct packed {
    logic                    valid;
    logic [31:0]             instr;
    logic [FETCH_ADDR_W-1:0] vaddr;
    logic                    xcpt;
  } fetch_resp_t;

endpackage

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: single-line fetch buffer with tag compare and word select.
//   clk_i, rstn_i   clock, async active-low reset
//   clr_i           invalidate the line (wins over a same-cycle fill)
//   fill_i          load fill_tag_i / fill_data_i / fill_xcpt_i
//   lookup_tag_i    tag of the current fetch address
//   lookup_sel_i    32-bit word index inside the line
//   match_o         line valid and tag equal
//   word_o          selected instruction word
//   xcpt_o          line was filled with an access fault
module fetch_line_buffer
  import drac_pkg::*;
#(
  parameter int LINE_W = ICACHE_LINE_W,
  parameter int OFF_W  = ICACHE_OFF_W,
  parameter int TAG_W  = FETCH_ADDR_W - ICACHE_OFF_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clr_i,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_data_i,
  input  logic              fill_xcpt_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  input  logic [OFF_W-3:0]  lookup_sel_i,
  output logic              match_o,
  output logic [31:0]       word_o,
  output logic              xcpt_o
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [LINE_W-1:0] data_q;
  logic              xcpt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      xcpt_q  <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
      xcpt_q  <= fill_xcpt_i;
    end
  end

  assign match_o = valid_q & (tag_q == lookup_tag_i);
  assign word_o  = data_q[{lookup_sel_i, 5'b00000} +: 32];
  assign xcpt_o  = xcpt_q;

endmodule

// File: rtl/icache_fetch_responder.sv
// icache_fetch_responder: serves fetch-stage-1 requests from a one-line
// buffer, fills the buffer from the icache on a miss and returns a registered
// instruction (or access fault) to fetch stage 2.
//   clk_i, rstn_i                 clock, async active-low reset
//   req_*_i                       fetch request and invalidation controls
//   stall_o                       fetch must hold its PC
//   icache_req_valid/vaddr_o, icache_req_ready_i   line request handshake
//   icache_kill_o                 abort an outstanding fill
//   icache_invalidate_o           registered flush pulse to the icache
//   icache_resp_valid/data/xcpt_i line fill from the icache
//   resp_valid/instr/vaddr/xcpt_o response to fetch stage 2
//   hit_cnt_o, miss_cnt_o         only with ICACHE_FETCH_PERF_EN defined
//
// state | meaning
// IDLE  | serving hits from the buffer, a miss starts a line request
// REQ   | line request presented, waiting for icache ready
// WAIT  | request accepted, waiting for the fill
// DROP  | fill aborted, swallowing the one response still in flight
module icache_fetch_responder
  import drac_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int LINE_W = ICACHE_LINE_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_vaddr_i,
  input  logic              req_invalidate_icache_i,
  input  logic              req_invalidate_buffer_i,
  input  logic              req_inval_fetch_i,
  output logic              stall_o,
  output logic              icache_req_valid_o,
  output logic [ADDR_W-1:0] icache_req_vaddr_o,
  input  logic              icache_req_ready_i,
  output logic              icache_kill_o,
  output logic              icache_invalidate_o,
  input  logic              icache_resp_valid_i,
  input  logic [LINE_W-1:0] icache_resp_data_i,
  input  logic              icache_resp_xcpt_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_instr_o,
  output logic [ADDR_W-1:0] resp_vaddr_o,
  output logic              resp_xcpt_o
`ifdef ICACHE_FETCH_PERF_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int TAG_W = ADDR_W - OFF_W;

  fetch_resp_state_t state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  fetch_resp_t       resp_q, resp_d;
  logic              inval_q;

  logic              buf_clr;
  logic              buf_fill;
  logic              buf_match;
  logic [31:0]       buf_word;
  logic              buf_xcpt;
  logic              hit;

  // Either invalidation hides the buffer in the same cycle and clears it.
  assign buf_clr = req_invalidate_buffer_i | req_invalidate_icache_i;
  assign hit     = buf_match & ~buf_clr;

  fetch_line_buffer #(
    .LINE_W (LINE_W),
    .OFF_W  (OFF_W),
    .TAG_W  (TAG_W)
  ) u_line_buffer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clr_i        (buf_clr),
    .fill_i       (buf_fill),
    .fill_tag_i   (tag_q),
    .fill_data_i  (icache_resp_data_i),
    .fill_xcpt_i  (icache_resp_xcpt_i),
    .lookup_tag_i (req_vaddr_i[ADDR_W-1:OFF_W]),
    .lookup_sel_i (req_vaddr_i[OFF_W-1:2]),
    .match_o      (buf_match),
    .word_o       (buf_word),
    .xcpt_o       (buf_xcpt)
  );

  always_comb begin
    state_d            = state_q;
    tag_d              = tag_q;
    resp_d             = '0;
    stall_o            = 1'b0;
    icache_req_valid_o = 1'b0;
    icache_kill_o      = 1'b0;
    buf_fill           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (hit) begin
            resp_d.valid = 1'b1;
            resp_d.instr = buf_xcpt ? 32'h0 : buf_word;
            resp_d.vaddr = req_vaddr_i;
            resp_d.xcpt  = buf_xcpt;
          end else begin
            stall_o = 1'b1;
            tag_d   = req_vaddr_i[ADDR_W-1:OFF_W];
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        // A retry withdraws valid so no handshake can complete this cycle.
        if (req_inval_fetch_i) begin
          state_d = IDLE;
        end else begin
          icache_req_valid_o = 1'b1;
          if (icache_req_ready_i) state_d = WAIT;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (icache_resp_valid_i) begin
          buf_fill = ~req_inval_fetch_i;
          state_d  = IDLE;
        end else if (req_inval_fetch_i) begin
          icache_kill_o = 1'b1;
          state_d       = DROP;
        end
      end
      DROP: begin
        stall_o = 1'b1;
        if (icache_resp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      tag_q   <= '0;
      resp_q  <= '0;
      inval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      resp_q  <= resp_d;
      inval_q <= req_invalidate_icache_i;
    end
  end

  assign icache_req_vaddr_o  = icache_req_valid_o ? {tag_q, {OFF_W{1'b0}}} : '0;
  assign icache_invalidate_o = inval_q;
  assign resp_valid_o        = resp_q.valid;
  assign resp_instr_o        = resp_q.instr;
  assign resp_vaddr_o        = resp_q.vaddr;
  assign resp_xcpt_o         = resp_q.xcpt;

`ifdef ICACHE_FETCH_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (resp_q.valid) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == IDLE) && (state_d == REQ)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- Responder end of the fetch-stage-1 → icache request interface.
- Consumes per-cycle fetch requests (valid, 40-bit vaddr, invalidate_icache, invalidate_buffer, inval_fetch) and serves them from a one-line fetch buffer.
- On a buffer miss, issues a line fill to the icache and stalls fetch until the fill completes.
- Delivers a registered 32-bit instruction or access-fault to fetch stage 2.

Parameters:
- ADDR_W, 40, virtual fetch address width.
- LINE_W, 128, icache line width in bits; word select = vaddr[$clog2(LINE_W/8)-1:2].

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  fetch request valid.
- req_vaddr_i  in  ADDR_W  fetch address; [1:0] ignored.
- req_invalidate_icache_i  in  1  flush icache.
- req_invalidate_buffer_i  in  1  clear fetch buffer.
- req_inval_fetch_i  in  1  abort outstanding fill (retry).
- stall_o  out  1  fetch must hold PC.
- icache_req_valid_o  out  1  line request valid.
- icache_req_vaddr_o  out  ADDR_W  line-aligned address.
- icache_req_ready_i  in  1  icache accepts request.
- icache_kill_o  out  1  kill outstanding fill.
- icache_invalidate_o  out  1  flush pulse to icache.
- icache_resp_valid_i  in  1  fill data valid.
- icache_resp_data_i  in  LINE_W  fill line.
- icache_resp_xcpt_i  in  1  access fault on fill.
- resp_valid_o  out  1  instruction valid to stage 2.
- resp_instr_o  out  32  instruction word.
- resp_vaddr_o  out  ADDR_W  address of the instruction.
- resp_xcpt_o  out  1  instruction access fault.

Behaviour:
- Reset: state IDLE; buf_valid=0; all outputs 0.
- Buffer fields: buf_valid, buf_tag = vaddr[ADDR_W-1:OFF], buf_data (LINE_W), buf_xcpt.
- hit = buf_valid & tag match & !req_invalidate_buffer_i & !req_invalidate_icache_i.
- State IDLE:
  - req_valid_i & hit: the next cycle drives resp_valid_o=1, resp_instr_o = selected 32-bit word, resp_vaddr_o = request address, resp_xcpt_o = buf_xcpt. One-cycle latency; back-to-back hits give full throughput.
  - req_valid_i & !hit: stall_o=1 combinationally in the same cycle; latch line address; go to REQ.
- State REQ: icache_req_valid_o=1 with line address held; on icache_req_ready_i go to WAIT.
- State WAIT: on icache_resp_valid_i, fill the buffer:
  - buf_data = data, buf_tag = latched tag, buf_xcpt = xcpt, buf_valid = 1.
  - Go to IDLE.
- stall_o = (state != IDLE) | (req_valid_i & !hit). Fetch holds the request, so it hits the filled buffer the cycle after the fill.
  - Miss latency = handshake + fill + 1 cycle.
  - A faulting fill is served as a hit with resp_xcpt_o=1 and resp_instr_o=0.
- req_inval_fetch_i:
  - In REQ: drop the request and go to IDLE (nothing handshaken).
  - In WAIT: pulse icache_kill_o and go to DROP.
  - In WAIT with icache_resp_valid_i in the same cycle: discard the data, no fill, go to IDLE.
- State DROP: stall_o=1; discard the next icache_resp_valid_i; then go to IDLE.
- req_invalidate_buffer_i or req_invalidate_icache_i: buf_valid=0 next cycle. This takes priority over a same-cycle fill, i.e. the fill is discarded.
- req_invalidate_icache_i produces a one-cycle registered icache_invalidate_o pulse.
- resp_valid_o=0 on every cycle not following an IDLE hit.
- Width rules: resp_vaddr_o is the full request address. The tag compare excludes the offset bits.

Optional Feature:
- Macro ICACHE_FETCH_PERF_EN.
- Defined: adds outputs hit_cnt_o and miss_cnt_o (32 bits each, wrapping, reset 0).
  - hit_cnt_o increments on each delivered resp_valid_o.
  - miss_cnt_o increments on each IDLE→REQ transition.
- Undefined: neither the ports nor the counters exist; the rest of the behaviour is identical.

Decomposition:
- drac_pkg holds:
  - ICACHE_LINE_W and the derived ICACHE_OFF_W.
  - typedef icache_line_t.
  - enum fetch_resp_state_t {IDLE, REQ, WAIT, DROP}.
  - struct fetch_resp_t {valid, instr, vaddr, xcpt}.
- One sub-module: fetch_line_buffer, holding the buffer registers, tag compare and word select. The FSM stays in the top module.

Test Plan:
- Cold miss: vaddr 0x80000004 → stall_o=1 at once; icache_req_vaddr_o=0x80000000. After ready and fill with word1=0x00000013, the next cycle gives resp_valid_o=1, instr 0x00000013, stall_o=0.
- Hit streak: addresses 0x80000000..0x8000000C on consecutive cycles after the fill → 4 consecutive responses, no stall, words 0..3.
- Fault fill: icache_resp_xcpt_i=1 for 0x10000 → resp_xcpt_o=1, resp_vaddr_o=0x10000, instr 0.
- Retry in WAIT: req_inval_fetch_i → icache_kill_o pulse; late resp_valid discarded; buf_valid stays 0; re-request misses again.
- Invalidate vs fill in the same cycle: req_invalidate_buffer_i with icache_resp_valid_i → buffer invalid; the next request to that line misses.
- Reset mid-WAIT: rstn_i low → state IDLE, all outputs 0, buffer invalid; no response emitted after release.
